// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: default register
// address width and the FSM state encoding seen on state_o.
package pipe_pkg;

   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DSTALL = 2'd1,
      ST_FLUSH  = 2'd2
   } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_slot_cmp.sv
// One scoreboard slot compared against the ID instruction's sources.
// Register 0 never matches; i_en lets the top switch a slot out entirely.
module hazard_slot_cmp #(
   parameter int REG_AW = 5
) (
   input  logic              i_en,
   input  logic              i_slot_v,
   input  logic [REG_AW-1:0] i_slot_rd,
   input  logic [REG_AW-1:0] i_rs,
   input  logic [REG_AW-1:0] i_rt,
   input  logic              i_use_rs,
   input  logic              i_use_rt,
   output logic              o_match
);

   logic w_rs_hit;
   logic w_rt_hit;

   assign w_rs_hit = i_use_rs && (i_rs != '0) && (i_rs == i_slot_rd);
   assign w_rt_hit = i_use_rt && (i_rt != '0) && (i_rt == i_slot_rd);
   assign o_match  = i_en && i_slot_v && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipe without forwarding.
// Tracks destination registers of EX/MEM/WB, stalls ID on RAW hazards and
// squashes the wrong path when the branch in MEM is taken.
//
// Handshake: there is no valid/ready pair; pc_write_o / if_id_write_o act as
// the "ready" back to fetch (low = hold), and id_valid_i qualifies ID. Stall
// and flush take effect in the same cycle as their cause; flush beats stall.
module pipe_hazard_ctrl #(
   parameter int REG_AW    = pipe_pkg::REG_AW,
   parameter int WB_BYPASS = 0,
   parameter int CNT_W     = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic              id_use_rs_i,
   input  logic              id_use_rt_i,
   input  logic              id_reg_write_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              mem_branch_taken_i,
   output logic              pc_write_o,
   output logic              if_id_write_o,
   output logic              if_id_flush_o,
   output logic              id_ex_bubble_o,
   output logic              ex_mem_flush_o,
   output logic [1:0]        state_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   import pipe_pkg::*;

   // With write-before-read register file the WB producer is already visible.
   localparam logic L_WB_CHK = (WB_BYPASS == 0);

   logic              r_ex_v, r_mem_v, r_wb_v;
   logic [REG_AW-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
   state_e            r_state;
   state_e            w_state_nxt;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;
   logic              w_ex_match, w_mem_match, w_wb_match;
   logic              w_hazard, w_flush, w_stall;

   hazard_slot_cmp #(.REG_AW(REG_AW)) u_cmp_ex (
      .i_en(1'b1), .i_slot_v(r_ex_v), .i_slot_rd(r_ex_rd),
      .i_rs(id_rs_i), .i_rt(id_rt_i), .i_use_rs(id_use_rs_i),
      .i_use_rt(id_use_rt_i), .o_match(w_ex_match)
   );

   hazard_slot_cmp #(.REG_AW(REG_AW)) u_cmp_mem (
      .i_en(1'b1), .i_slot_v(r_mem_v), .i_slot_rd(r_mem_rd),
      .i_rs(id_rs_i), .i_rt(id_rt_i), .i_use_rs(id_use_rs_i),
      .i_use_rt(id_use_rt_i), .o_match(w_mem_match)
   );

   hazard_slot_cmp #(.REG_AW(REG_AW)) u_cmp_wb (
      .i_en(L_WB_CHK), .i_slot_v(r_wb_v), .i_slot_rd(r_wb_rd),
      .i_rs(id_rs_i), .i_rt(id_rt_i), .i_use_rs(id_use_rs_i),
      .i_use_rt(id_use_rt_i), .o_match(w_wb_match)
   );

   assign w_hazard = id_valid_i && (w_ex_match || w_mem_match || w_wb_match);
   assign w_flush  = mem_branch_taken_i;
   assign w_stall  = w_hazard && !w_flush;

   assign pc_write_o     = !w_stall;
   assign if_id_write_o  = !w_stall;
   assign if_id_flush_o  = w_flush;
   assign id_ex_bubble_o = w_stall || w_flush;
   assign ex_mem_flush_o = w_flush;
   assign state_o        = r_state;
   assign stall_cnt_o    = r_stall_cnt;
   assign flush_cnt_o    = r_flush_cnt;

   // Shadow scoreboard: advance with the pipe, inserting bubbles on stall/flush.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ex_v   <= 1'b0;
         r_ex_rd  <= '0;
         r_mem_v  <= 1'b0;
         r_mem_rd <= '0;
         r_wb_v   <= 1'b0;
         r_wb_rd  <= '0;
      end else begin
         r_wb_v   <= r_mem_v;
         r_wb_rd  <= r_mem_rd;
         r_mem_v  <= w_flush ? 1'b0 : r_ex_v;
         r_mem_rd <= w_flush ? '0 : r_ex_rd;
         if (w_stall || w_flush || !id_valid_i) begin
            r_ex_v  <= 1'b0;
            r_ex_rd <= '0;
         end else begin
            r_ex_v  <= id_reg_write_i && (id_rd_i != '0);
            r_ex_rd <= id_rd_i;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= ST_RUN;
      else        r_state <= w_state_nxt;
   end

   // Next state records this cycle's condition; flush outranks stall everywhere.
   always_comb begin
      w_state_nxt = ST_RUN;
      case (r_state)
         ST_RUN, ST_DSTALL, ST_FLUSH: begin
            if (w_flush)      w_state_nxt = ST_FLUSH;
            else if (w_stall) w_state_nxt = ST_DSTALL;
            else              w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // Saturating stall and flush event counters.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Two instances share the same stimulus:
// d0 checks WB (WB_BYPASS=0), d1 skips it (WB_BYPASS=1); both use CNT_W=4.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_reg_write = 1'b0;
  logic       br = 1'b0;

  logic       pcw_0, ifw_0, iff_0, bub_0, emf_0;
  logic [1:0] st_0;
  logic [3:0] scnt_0, fcnt_0;
  logic       pcw_1, ifw_1, iff_1, bub_1, emf_1;
  logic [1:0] st_1;
  logic [3:0] scnt_1, fcnt_1;

  int n_pass = 0;
  int n_total = 0;

  // clock / reset block
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .WB_BYPASS(0), .CNT_W(4)) d0 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs),
    .id_rt_i(id_rt), .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
    .id_reg_write_i(id_reg_write), .id_rd_i(id_rd), .mem_branch_taken_i(br),
    .pc_write_o(pcw_0), .if_id_write_o(ifw_0), .if_id_flush_o(iff_0),
    .id_ex_bubble_o(bub_0), .ex_mem_flush_o(emf_0), .state_o(st_0),
    .stall_cnt_o(scnt_0), .flush_cnt_o(fcnt_0)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .WB_BYPASS(1), .CNT_W(4)) d1 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs),
    .id_rt_i(id_rt), .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
    .id_reg_write_i(id_reg_write), .id_rd_i(id_rd), .mem_branch_taken_i(br),
    .pc_write_o(pcw_1), .if_id_write_o(ifw_1), .if_id_flush_o(iff_1),
    .id_ex_bubble_o(bub_1), .ex_mem_flush_o(emf_1), .state_o(st_1),
    .stall_cnt_o(scnt_1), .flush_cnt_o(fcnt_1)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic rw,
                        input logic [4:0] rd, input logic b);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_reg_write = rw; id_rd = rd; br = b;
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  // add $3 : writes r3, reads nothing relevant
  task automatic issue_add3();
    set_in(1, 0, 0, 0, 0, 1, 3, 0);
  endtask

  // sub reading rs=3, no write-back
  task automatic issue_sub_rs3();
    set_in(1, 3, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    issue_add3();
    tick();
    issue_sub_rs3();
    n_total++; if (pcw_0 !== 1'b0) $display("FAIL pre_reset_stall: pc_write=%b want 0", pcw_0); else n_pass++;
    tick();
    n_total++; if (st_0 !== 2'd1) $display("FAIL pre_reset_state: state=%0d want 1", st_0); else n_pass++;
    // asynchronous assert mid-cycle, mid-stall
    #2 rst = 1'b0;
    #1;
    n_total++; if (st_0 !== 2'd0) $display("FAIL rst_state: state=%0d want 0", st_0); else n_pass++;
    n_total++; if (scnt_0 !== 4'd0) $display("FAIL rst_stall_cnt: cnt=%0d want 0", scnt_0); else n_pass++;
    n_total++; if (fcnt_0 !== 4'd0) $display("FAIL rst_flush_cnt: cnt=%0d want 0", fcnt_0); else n_pass++;
    n_total++; if (pcw_0 !== 1'b1 || ifw_0 !== 1'b1) $display("FAIL rst_pc_write: pc=%b ifid=%b want 1 1", pcw_0, ifw_0); else n_pass++;
    n_total++; if ({iff_0, bub_0, emf_0} !== 3'b000) $display("FAIL rst_flush_outs: %b want 000", {iff_0, bub_0, emf_0}); else n_pass++;
    #2 rst = 1'b1;
    tick();
    issue_sub_rs3();
    n_total++; if (pcw_0 !== 1'b1 || pcw_1 !== 1'b1) $display("FAIL post_rst_no_stall: pc=%b/%b want 1/1", pcw_0, pcw_1); else n_pass++;
    tick();
    n_total++; if (scnt_0 !== 4'd0) $display("FAIL post_rst_stall_cnt: cnt=%0d want 0", scnt_0); else n_pass++;
  endtask

  task automatic test_raw();
    logic e0, e1;
    do_reset();
    issue_add3();
    n_total++; if (pcw_0 !== 1'b1) $display("FAIL raw_producer: pc_write=%b want 1", pcw_0); else n_pass++;
    tick();
    issue_sub_rs3();
    for (int i = 0; i < 5; i++) begin
      e0 = (i < 3);
      e1 = (i < 2);
      n_total++; if (pcw_0 !== !e0) $display("FAIL raw_bp0_pc c%0d: pc_write=%b want %b", i, pcw_0, !e0); else n_pass++;
      n_total++; if (bub_0 !== e0) $display("FAIL raw_bp0_bubble c%0d: bubble=%b want %b", i, bub_0, e0); else n_pass++;
      n_total++; if (pcw_1 !== !e1) $display("FAIL raw_bp1_pc c%0d: pc_write=%b want %b", i, pcw_1, !e1); else n_pass++;
      n_total++; if (bub_1 !== e1) $display("FAIL raw_bp1_bubble c%0d: bubble=%b want %b", i, bub_1, e1); else n_pass++;
      tick();
    end
    n_total++; if (scnt_0 !== 4'd3) $display("FAIL raw_bp0_cnt: stall_cnt=%0d want 3", scnt_0); else n_pass++;
    n_total++; if (scnt_1 !== 4'd2) $display("FAIL raw_bp1_cnt: stall_cnt=%0d want 2", scnt_1); else n_pass++;
    n_total++; if (st_0 !== 2'd0 || st_1 !== 2'd0) $display("FAIL raw_state_back: state=%0d/%0d want 0/0", st_0, st_1); else n_pass++;
  endtask

  task automatic test_reg0_unused();
    do_reset();
    set_in(1, 0, 0, 0, 0, 1, 0, 0);   // writes $0
    tick();
    set_in(1, 0, 0, 1, 0, 0, 0, 0);   // reads rs=0
    n_total++; if (pcw_0 !== 1'b1) $display("FAIL reg0_no_stall: pc_write=%b want 1", pcw_0); else n_pass++;
    set_in(1, 0, 0, 0, 0, 1, 5, 0);   // writes $5
    tick();
    set_in(1, 1, 5, 1, 0, 1, 6, 0);   // addi rt=5, rt unused
    n_total++; if (pcw_0 !== 1'b1) $display("FAIL unused_rt_no_stall: pc_write=%b want 1", pcw_0); else n_pass++;
    set_in(1, 1, 5, 1, 1, 0, 0, 0);   // same but rt used
    n_total++; if (pcw_0 !== 1'b0 || pcw_1 !== 1'b0) $display("FAIL used_rt_stall: pc_write=%b/%b want 0/0", pcw_0, pcw_1); else n_pass++;
    set_in(0, 1, 5, 1, 1, 0, 0, 0);   // same hazard, but ID holds a bubble
    n_total++; if (pcw_0 !== 1'b1) $display("FAIL invalid_no_stall: pc_write=%b want 1", pcw_0); else n_pass++;
    tick();
    n_total++; if (scnt_0 !== 4'd0) $display("FAIL reg0_stall_cnt: cnt=%0d want 0", scnt_0); else n_pass++;
  endtask

  task automatic test_branch();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 1);
    n_total++; if ({iff_0, bub_0, emf_0} !== 3'b111) $display("FAIL br_flush_outs: %b want 111", {iff_0, bub_0, emf_0}); else n_pass++;
    n_total++; if (pcw_0 !== 1'b1) $display("FAIL br_pc_write: pc_write=%b want 1", pcw_0); else n_pass++;
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    n_total++; if (st_0 !== 2'd2) $display("FAIL br_state: state=%0d want 2", st_0); else n_pass++;
    n_total++; if (fcnt_0 !== 4'd1) $display("FAIL br_flush_cnt: cnt=%0d want 1", fcnt_0); else n_pass++;
    n_total++; if ({iff_0, bub_0, emf_0} !== 3'b000) $display("FAIL br_outs_clear: %b want 000", {iff_0, bub_0, emf_0}); else n_pass++;
    tick();
    n_total++; if (st_0 !== 2'd0) $display("FAIL br_state_run: state=%0d want 0", st_0); else n_pass++;
  endtask

  task automatic test_branch_and_stall();
    do_reset();
    issue_add3();
    tick();
    issue_sub_rs3();
    n_total++; if (pcw_0 !== 1'b0) $display("FAIL bs_stalled: pc_write=%b want 0", pcw_0); else n_pass++;
    br = 1'b1;
    #1;
    n_total++; if (pcw_0 !== 1'b1) $display("FAIL bs_stall_dropped: pc_write=%b want 1", pcw_0); else n_pass++;
    n_total++; if ({iff_0, bub_0, emf_0} !== 3'b111) $display("FAIL bs_flush_outs: %b want 111", {iff_0, bub_0, emf_0}); else n_pass++;
    tick();
    issue_sub_rs3();   // br back to 0; EX slot must now be empty
    n_total++; if (st_0 !== 2'd2) $display("FAIL bs_state: state=%0d want 2", st_0); else n_pass++;
    n_total++; if (scnt_0 !== 4'd0) $display("FAIL bs_stall_cnt: cnt=%0d want 0", scnt_0); else n_pass++;
    n_total++; if (fcnt_0 !== 4'd1) $display("FAIL bs_flush_cnt: cnt=%0d want 1", fcnt_0); else n_pass++;
    n_total++; if (pcw_0 !== 1'b1 || pcw_1 !== 1'b1) $display("FAIL bs_ex_slot_cleared: pc_write=%b/%b want 1/1", pcw_0, pcw_1); else n_pass++;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    // 7 rounds: d0 stalls 3 per round (21 = 2^4+5), d1 stalls 2 per round (14)
    for (int r = 0; r < 7; r++) begin
      issue_add3();
      tick();
      issue_sub_rs3();
      for (int c = 0; c < 4; c++) tick();
    end
    n_total++; if (scnt_0 !== 4'd15) $display("FAIL sat_stall_bp0: cnt=%0d want 15", scnt_0); else n_pass++;
    n_total++; if (scnt_1 !== 4'd14) $display("FAIL sat_stall_bp1: cnt=%0d want 14", scnt_1); else n_pass++;
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 20; c++) tick();
    n_total++; if (fcnt_0 !== 4'd15) $display("FAIL sat_flush: cnt=%0d want 15", fcnt_0); else n_pass++;
    n_total++; if (scnt_0 !== 4'd15) $display("FAIL sat_stall_hold: cnt=%0d want 15", scnt_0); else n_pass++;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_reg0_unused();
    test_branch();
    test_branch_and_stall();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
